// File: rtl/mem_burst_wr.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_wr
// Description : Turns one burst command into a run of single-beat memory writes.
//               Write data arrives on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_wr #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  C_LEN_ONE  = 1;
  localparam logic [LEN_WIDTH-1:0]  C_LEN_ZERO = '0;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_cmd_ready;
  logic                  r_wdata_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_busy;
  logic                  r_done;

  logic w_cmd_fire;
  logic w_beat_fire;
  logic w_last_beat;

  assign w_cmd_fire  = cmd_valid & r_cmd_ready;
  assign w_beat_fire = wdata_valid & r_wdata_ready;
  // Counting down to zero keeps an all-ones length from ever overflowing.
  assign w_last_beat = (r_remaining == C_LEN_ZERO);

  assign cmd_ready   = r_cmd_ready;
  assign wdata_ready = r_wdata_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign busy        = r_busy;
  assign done        = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_cmd_ready   <= 1'b1;
      r_wdata_ready <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cur_addr    <= cmd_addr;
            r_remaining   <= cmd_len;
            r_cmd_ready   <= 1'b0;
            r_wdata_ready <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_beat_fire) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_cur_addr;
            r_mem_data <= wdata;
            r_cur_addr <= r_cur_addr + C_ADDR_ONE;
            if (w_last_beat) begin
              r_wdata_ready <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_remaining <= r_remaining - C_LEN_ONE;
            end
          end
        end
        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready   <= 1'b1;
          r_wdata_ready <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_wr
// Description : Self-checking bench for mem_burst_wr against a beat-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [7:0]  wdata = '0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_data = '0;

  mem_burst_wr #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Asynchronous reset pulse, checked the instant it is asserted.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_we, done, busy, cmd_ready, wdata_ready} !== 5'b00010 || mem_addr !== 16'h0 || mem_data !== 8'h0) begin
      miss_cnt++;
      $display("FAIL %s: we/done/busy/cready/wready=%b addr=%h data=%h, required 00010 0000 00",
               tag, {mem_we, done, busy, cmd_ready, wdata_ready}, mem_addr, mem_data);
    end
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one burst. The model: beat k goes to start+k (mod 2^16), each handshake
  // shows up as a write after the next edge, done coincides with the final write.
  task automatic run_burst(input logic [15:0] addr, input logic [3:0] len, input int stall_pct,
                           input logic [31:0] vpat, input int plen, input int dbase,
                           input bit hold_next, input logic [15:0] next_addr,
                           input logic [3:0] next_len, input int abort_after);
    int          waitc = 0;
    int          total;
    int          beats = 0;
    int          cyc = 0;
    logic        v;
    logic        exp_done;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;

    @(negedge clk);
    while (cmd_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL cmd_wait: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
      pulse_reset("cmd_wait_recover");
      return;
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk);
    #1;
    vec_cnt++;
    if ({cmd_ready, wdata_ready, busy, done, mem_we} !== 5'b01100) begin
      miss_cnt++;
      $display("FAIL cmd_accept: cready/wready/busy/done/we=%b, required 01100",
               {cmd_ready, wdata_ready, busy, done, mem_we});
    end
    vec_cnt++;
    if (mem_addr !== last_addr || mem_data !== last_data) begin
      miss_cnt++;
      $display("FAIL hold_idle: addr=%h data=%h, required %h %h", mem_addr, mem_data, last_addr, last_data);
    end
    if (hold_next) begin
      cmd_addr = next_addr;
      cmd_len  = next_len;
    end else begin
      cmd_valid = 1'b0;
    end

    total = int'(len) + 1;
    while (beats < total && cyc < 400) begin
      @(negedge clk);
      cyc++;
      vec_cnt++;
      if (wdata_ready !== 1'b1 || cmd_ready !== 1'b0) begin
        miss_cnt++;
        $display("FAIL burst_ready: wready=%b cready=%b, required 1 0", wdata_ready, cmd_ready);
      end
      if (plen > 0) v = (cyc - 1 < plen) ? vpat[cyc-1] : 1'b1;
      else          v = ($urandom_range(99) >= stall_pct);
      wdata_valid = v;
      wdata       = (dbase >= 0) ? 8'(dbase + beats) : 8'($urandom);
      exp_addr    = addr + 16'(beats);
      exp_data    = wdata;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (v) begin
        beats++;
        if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_data !== exp_data) begin
          miss_cnt++;
          $display("FAIL write beat %0d: we=%b addr=%h data=%h, required 1 %h %h",
                   beats, mem_we, mem_addr, mem_data, exp_addr, exp_data);
        end
        last_addr = exp_addr;
        last_data = exp_data;
      end else if (mem_we !== 1'b0 || mem_addr !== last_addr || mem_data !== last_data) begin
        miss_cnt++;
        $display("FAIL stall: we=%b addr=%h data=%h, required 0 %h %h",
                 mem_we, mem_addr, mem_data, last_addr, last_data);
      end
      exp_done = (beats == total);
      vec_cnt++;
      if (done !== exp_done || busy !== 1'b1) begin
        miss_cnt++;
        $display("FAIL done_busy: done=%b busy=%b, required %b 1", done, busy, exp_done);
      end
      if (abort_after >= 0 && beats == abort_after && beats < total) begin
        wdata_valid = 1'b0;
        pulse_reset("async_reset");
        // Remaining beats are offered but must not be taken without a command.
        wdata_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({mem_we, done, busy, cmd_ready, wdata_ready} !== 5'b00010) begin
          miss_cnt++;
          $display("FAIL post_reset_ignore: we/done/busy/cready/wready=%b, required 00010",
                   {mem_we, done, busy, cmd_ready, wdata_ready});
        end
        wdata_valid = 1'b0;
        return;
      end
    end
    if (beats < total) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL burst_timeout: %0d of %0d beats accepted", beats, total);
      wdata_valid = 1'b0;
      pulse_reset("timeout_recover");
      return;
    end

    // DONE cycle: a further beat is offered and must be ignored.
    @(negedge clk);
    vec_cnt++;
    if (wdata_ready !== 1'b0 || cmd_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL done_ready: wready=%b cready=%b, required 0 0", wdata_ready, cmd_ready);
    end
    wdata_valid = 1'b1;
    wdata       = 8'($urandom);
    @(posedge clk);
    #1;
    vec_cnt++;
    if ({cmd_ready, busy, done, mem_we, wdata_ready} !== 5'b10000 || mem_addr !== last_addr) begin
      miss_cnt++;
      $display("FAIL back_to_idle: cready/busy/done/we/wready=%b addr=%h, required 10000 %h",
               {cmd_ready, busy, done, mem_we, wdata_ready}, mem_addr, last_addr);
    end
    wdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({cmd_ready, wdata_ready, busy, done, mem_we} !== 5'b10000 || mem_addr !== 16'h0 || mem_data !== 8'h0) begin
      miss_cnt++;
      $display("FAIL reset: cready/wready/busy/done/we=%b addr=%h data=%h, required 10000 0000 00",
               {cmd_ready, wdata_ready, busy, done, mem_we}, mem_addr, mem_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(16'h0010, 4'd3, 0, 32'h0000_000F, 4, 8'hA1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_single();
    run_burst(16'h1234, 4'd0, 0, 32'h0000_0001, 1, 8'h5A, 1'b0, '0, '0, -1);
  endtask

  task automatic test_wrap();
    run_burst(16'hFFFE, 4'd3, 0, 32'h0, 0, -1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_stall();
    // valid sequence 1,0,0,1,0,1 (bit 0 first)
    run_burst(16'h0400, 4'd2, 0, 32'b101001, 6, -1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_back_to_back();
    run_burst(16'h0A00, 4'd4, 20, 32'h0, 0, -1, 1'b1, 16'h0B80, 4'd2, -1);
    run_burst(16'h0B80, 4'd2, 0, 32'h0, 0, -1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_reset_mid();
    run_burst(16'h0200, 4'd7, 0, 32'h0, 0, -1, 1'b0, '0, '0, 2);
    run_burst(16'h0300, 4'd2, 0, 32'h0, 0, -1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_max_len();
    run_burst(16'h8000, 4'hF, 0, 32'h0, 0, -1, 1'b0, '0, '0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_burst(16'($urandom), 4'($urandom), int'($urandom_range(60)), 32'h0, 0, -1,
                1'b0, '0, '0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_wr.md
Name: mem_burst_wr

Overview:
- Write initiator for the parameterized memory blocks: converts one burst command into a sequence of single-beat writes.
- Each command carries a start address and a beat count. The block takes write data over a valid/ready stream and drives registered addr/data/write-enable into the memory port.
- Sits between a DMA/testbench source and any memory instance that has addr/data inputs. The memory side has no backpressure: the memory accepts a write every cycle.

Parameters:
- addr_width, 16, memory address width in bits.
- data_width, 8, memory data width in bits.
- len_width, 4, width of cmd_len. Burst is cmd_len+1 beats, so 1 to 2**len_width beats.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  burst command present.
- cmd_ready  output  1  block accepts a command (IDLE only).
- cmd_addr  input  addr_width  start address.
- cmd_len  input  len_width  number of beats minus 1.
- wdata_valid  input  1  write data beat present.
- wdata_ready  output  1  block accepts a data beat (BURST only).
- wdata  input  data_width  write data.
- mem_we  output  1  registered write strobe, one cycle per beat.
- mem_addr  output  addr_width  registered write address.
- mem_data  output  data_width  registered write data.
- busy  output  1  high in BURST and DONE.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async assert, takes effect immediately) sets:
  - state to IDLE.
  - cmd_ready=1, wdata_ready=0, busy=0, done=0.
  - mem_we=0, mem_addr=0, mem_data=0.
  - internal address and beat counter to 0.
- Reset deasserts synchronously to clk. It has no ordering requirement against valid inputs.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cur_addr=cmd_addr and remaining=cmd_len, then go to BURST. wdata is ignored in IDLE.
  - BURST: wdata_ready=1, cmd_ready=0. On each cycle N with wdata_valid&&wdata_ready:
    - in cycle N+1: mem_we=1, mem_addr=cur_addr, mem_data=wdata.
    - cur_addr increments.
    - if remaining==0, go to DONE; otherwise remaining decrements.
    - If wdata_valid is low, mem_we=0 next cycle (stall, no write). Stalls of any length are legal.
  - DONE: one cycle. done=1, busy=1, cmd_ready=0, wdata_ready=0. The last beat's mem_we=1 lands in this same cycle. Next state is IDLE.
- Latency: wdata handshake to mem_we is exactly 1 cycle. Last handshake to the done pulse is 1 cycle. After done, cmd_ready returns 1 on the following cycle.
- Throughput: one beat per cycle with wdata_valid held high. A burst of L+1 beats takes 1 command cycle + L+1 data cycles + 1 DONE cycle.
- Address arithmetic: cur_addr increments modulo 2**addr_width. A burst crossing the top address wraps to 0 with no error.
- mem_addr and mem_data hold their last values while mem_we=0.
- A command arriving while busy is not accepted (cmd_ready=0). The source must hold it until cmd_ready.
- cmd_len=0 means a single beat. cmd_len of all ones means 2**len_width beats. The counter must not overflow.
- Reset mid-burst:
  - the burst is abandoned, with no further mem_we and no done pulse.
  - remaining beats offered after reset are not accepted until a new command.

Test Plan:
- Reset then cmd addr=0x0010, len=3, with wdata 0xA1,0xA2,0xA3,0xA4 on back-to-back cycles -> mem_we high 4 consecutive cycles with addr 0x0010..0x0013 and data 0xA1..0xA4; done pulses coincident with the 4th write; cmd_ready=1 next cycle.
- cmd len=0, addr=0x1234, wdata 0x5A -> exactly one write (0x1234,0x5A); done 1 cycle after handshake; busy high 2 cycles.
- Wrap: addr=0xFFFE, len=3 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Stalls: len=2, wdata_valid toggled 1,0,0,1,0,1 -> mem_we pattern 1,0,0,1,0,1 (delayed 1 cycle); addresses consecutive; done only after the 3rd beat.
- Second cmd_valid held high during a burst -> not accepted until cmd_ready returns; then it executes with its own addr/len.
- Assert rst after 2 of 8 beats -> mem_we=0 immediately, no done, cmd_ready=1 after release; the next command writes from its own start address.
- Max length: len=0xF -> 16 writes, then done; no 17th write.
